// File: rtl/led_period_ctrl.sv
// Rotating one-hot LED driver: steps the pattern once every time_value clock cycles.
// The run/pause FSM preserves the progress of the current period while paused.
module led_period_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] time_value,
    input  logic        allow_count,
    input  logic        dir,
    output logic [7:0]  led,
    output logic [2:0]  step,
    output logic        tick,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [26:0] tv_lat_q, tv_lat_d;
    logic [7:0]  led_q, led_d;
    logic [2:0]  step_q, step_d;
    logic        tick_q, tick_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tv_lat_d = tv_lat_q;
        led_d    = led_q;
        step_d   = step_q;
        tick_d   = 1'b0;

        // A zero period stops everything, whatever the current state.
        if (time_value == 27'd0) begin
            state_d = IDLE;
            cnt_d   = 27'd0;
            led_d   = 8'h01;
            step_d  = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (allow_count) begin
                        state_d  = RUN;
                        cnt_d    = 27'd0;
                        tv_lat_d = time_value;
                    end
                end
                RUN: begin
                    if (!allow_count) begin
                        state_d = PAUSE;
                    end else if (cnt_q == tv_lat_q - 27'd1) begin
                        // Period boundary: new period length and direction take effect here.
                        cnt_d    = 27'd0;
                        tick_d   = 1'b1;
                        tv_lat_d = time_value;
                        if (dir) begin
                            led_d  = {led_q[0], led_q[7:1]};
                            step_d = step_q - 3'd1;
                        end else begin
                            led_d  = {led_q[6:0], led_q[7]};
                            step_d = step_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 27'd1;
                    end
                end
                PAUSE: begin
                    if (allow_count) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 27'd0;
                    led_d   = 8'h01;
                    step_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 27'd0;
            tv_lat_q <= 27'd0;
            led_q    <= 8'h01;
            step_q   <= 3'd0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tv_lat_q <= tv_lat_d;
            led_q    <= led_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
        end
    end

    assign led   = led_q;
    assign step  = step_q;
    assign tick  = tick_q;
    assign state = state_q;

endmodule

// File: tb/tb_led_period_ctrl.sv
// Directed bench for led_period_ctrl: a vector table for the basic flow plus
// hand-written sequences for pause/resume, period change, direction and async reset.
module tb_led_period_ctrl;

    logic        clk;
    logic        rst;
    logic [26:0] time_value;
    logic        allow_count;
    logic        dir;
    logic [7:0]  led;
    logic [2:0]  step;
    logic        tick;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    led_period_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .time_value  (time_value),
        .allow_count (allow_count),
        .dir         (dir),
        .led         (led),
        .step        (step),
        .tick        (tick),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] tv;
        logic        allow;
        logic        dr;
        logic [7:0]  exp_led;
        logic [2:0]  exp_step;
        logic        exp_tick;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic [26:0] tv, input logic al, input logic dr,
                                input logic [7:0] l, input logic [2:0] s,
                                input logic t, input logic [1:0] st);
        vec_t v;
        v.tv = tv; v.allow = al; v.dr = dr;
        v.exp_led = l; v.exp_step = s; v.exp_tick = t; v.exp_state = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Advance until tick is seen or maxn edges pass; n is the number of edges taken.
    task automatic wait_tick(input int maxn, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick && n < maxn);
    endtask

    initial begin
        int n;

        rst = 1'b1;
        time_value = 27'd0;
        allow_count = 1'b0;
        dir = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_led", 32'(led), 32'h01);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_tick", 32'(tick), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //            tv  al dir  led    step tick state
        vecs[0]  = mk(0,  0, 0, 8'h01, 3'd0, 0, 2'd0);
        vecs[1]  = mk(3,  0, 0, 8'h01, 3'd0, 0, 2'd0);
        vecs[2]  = mk(3,  1, 0, 8'h01, 3'd0, 0, 2'd1);
        vecs[3]  = mk(3,  1, 0, 8'h01, 3'd0, 0, 2'd1);
        vecs[4]  = mk(3,  1, 0, 8'h01, 3'd0, 0, 2'd1);
        vecs[5]  = mk(3,  1, 0, 8'h02, 3'd1, 1, 2'd1);
        vecs[6]  = mk(3,  0, 0, 8'h02, 3'd1, 0, 2'd2);
        vecs[7]  = mk(3,  0, 0, 8'h02, 3'd1, 0, 2'd2);
        vecs[8]  = mk(3,  1, 0, 8'h02, 3'd1, 0, 2'd1);
        vecs[9]  = mk(3,  1, 0, 8'h02, 3'd1, 0, 2'd1);
        vecs[10] = mk(3,  1, 0, 8'h02, 3'd1, 0, 2'd1);
        vecs[11] = mk(3,  1, 1, 8'h01, 3'd0, 1, 2'd1);
        vecs[12] = mk(3,  1, 1, 8'h01, 3'd0, 0, 2'd1);
        vecs[13] = mk(3,  1, 1, 8'h01, 3'd0, 0, 2'd1);
        vecs[14] = mk(3,  1, 1, 8'h80, 3'd7, 1, 2'd1);
        vecs[15] = mk(1,  1, 0, 8'h80, 3'd7, 0, 2'd1);
        vecs[16] = mk(1,  1, 0, 8'h80, 3'd7, 0, 2'd1);
        vecs[17] = mk(1,  1, 0, 8'h01, 3'd0, 1, 2'd1);
        vecs[18] = mk(1,  1, 0, 8'h02, 3'd1, 1, 2'd1);
        vecs[19] = mk(1,  1, 0, 8'h04, 3'd2, 1, 2'd1);
        vecs[20] = mk(0,  1, 0, 8'h01, 3'd0, 0, 2'd0);

        for (int i = 0; i < 21; i++) begin
            time_value  = vecs[i].tv;
            allow_count = vecs[i].allow;
            dir         = vecs[i].dr;
            cycle();
            chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].exp_step));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
        end

        // Period of 4, full rotation left.
        do_reset();
        time_value = 27'd4; allow_count = 1'b1; dir = 1'b0;
        cycle();
        chk("p4_run", 32'(state), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            wait_tick(10, n);
            chk($sformatf("p4_gap%0d", k), 32'(n), 32'd4);
            chk($sformatf("p4_led%0d", k), 32'(led), 32'(8'h01 << (k % 8)));
            chk($sformatf("p4_step%0d", k), 32'(step), 32'(k % 8));
        end

        // Pause after 3 advancing edges, resume, finish the period in 2 more.
        do_reset();
        time_value = 27'd5; allow_count = 1'b1; dir = 1'b0;
        cycle();
        repeat (3) cycle();
        allow_count = 1'b0;
        cycle();
        chk("pause_enter", 32'(state), 32'h2);
        repeat (9) cycle();
        chk("pause_hold", 32'(state), 32'h2);
        chk("pause_tick", 32'(tick), 32'h0);
        allow_count = 1'b1;
        cycle();
        chk("resume_state", 32'(state), 32'h1);
        chk("resume_tick", 32'(tick), 32'h0);
        wait_tick(10, n);
        chk("resume_gap", 32'(n), 32'd2);

        // Period change 5->3 mid-period takes effect only after the boundary.
        do_reset();
        time_value = 27'd5; allow_count = 1'b1; dir = 1'b0;
        cycle();
        repeat (2) cycle();
        time_value = 27'd3;
        wait_tick(10, n);
        chk("tvchg_first", 32'(n), 32'd3);
        wait_tick(10, n);
        chk("tvchg_second", 32'(n), 32'd3);
        wait_tick(10, n);
        chk("tvchg_third", 32'(n), 32'd3);

        // Rotate right from reset, then stop with a zero period.
        do_reset();
        time_value = 27'd2; allow_count = 1'b1; dir = 1'b1;
        cycle();
        wait_tick(10, n);
        chk("right_gap", 32'(n), 32'd2);
        chk("right_led", 32'(led), 32'h80);
        chk("right_step", 32'(step), 32'd7);
        time_value = 27'd0;
        cycle();
        chk("stop_state", 32'(state), 32'h0);
        chk("stop_led", 32'(led), 32'h01);
        chk("stop_step", 32'(step), 32'h0);

        // Asynchronous reset between edges while running.
        do_reset();
        time_value = 27'd2; allow_count = 1'b1; dir = 1'b0;
        cycle();
        wait_tick(10, n);
        chk("ar_pre_led", 32'(led), 32'h02);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_state", 32'(state), 32'h0);
        chk("ar_led", 32'(led), 32'h01);
        chk("ar_step", 32'(step), 32'h0);
        chk("ar_tick", 32'(tick), 32'h0);
        rst = 1'b0;
        cycle();
        chk("ar_restart_state", 32'(state), 32'h1);
        chk("ar_restart_led", 32'(led), 32'h01);
        wait_tick(10, n);
        chk("ar_restart_gap", 32'(n), 32'd2);
        chk("ar_restart_led2", 32'(led), 32'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_period_ctrl.md
LED_PERIOD_CTRL -- requirements
Module: led_period_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port time_value, input, 27 bits: step period in clk cycles; 0 = stop.
REQ-004 SHALL have port allow_count, input, 1 bit: 1 = run, 0 = pause.
REQ-005 SHALL have port dir, input, 1 bit: 0 = rotate left / step up, 1 = rotate right / step down.
REQ-006 SHALL have port led, output, 8 bits: one-hot LED pattern.
REQ-007 SHALL have port step, output, 3 bits: current pattern index, 0..7.
REQ-008 SHALL have port tick, output, 1 bit: one-cycle pulse per completed period.
REQ-009 SHALL have port state, output, 2 bits: FSM state, IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.
REQ-010 SHALL register all outputs; no combinational input-to-output path.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and PAUSE; encoding 2'b11 SHALL be unreachable and SHALL recover to IDLE on the next edge.
REQ-012 SHALL, in every state, go to IDLE on the next edge when time_value==0, with cnt=0, led=8'h01, step=0, tick=0; this rule has top priority.
REQ-013 SHALL go IDLE->RUN when allow_count=1 and time_value!=0: cnt=0, latch tv_lat=time_value.
REQ-014 SHALL go RUN->PAUSE when allow_count=0; on that edge cnt holds, tick=0.
REQ-015 SHALL go PAUSE->RUN when allow_count=1 and time_value!=0; cnt holds on the resume edge.
REQ-016 SHALL count an advancing edge only when state==RUN and allow_count==1 on that edge; cnt (27 bits) SHALL change only on advancing edges.
REQ-017 SHALL, on an advancing edge with cnt==tv_lat-1: set cnt=0, tick=1 for exactly one cycle, update led/step, reload tv_lat=time_value; otherwise cnt+1, tick=0.
REQ-018 SHALL make each period exactly tv_lat advancing edges; paused cycles SHALL NOT count and remaining progress SHALL be preserved.
REQ-019 SHALL, for tv_lat=1, hold tick high on every advancing edge (continuous).
REQ-020 SHALL apply a time_value change (nonzero) only at the next period boundary; the current period completes with the old tv_lat.
REQ-021 SHALL sample dir at the period boundary: dir=0 -> led rotate left (8'h80 wraps to 8'h01), step+1 mod 8; dir=1 -> rotate right (8'h01 wraps to 8'h80), step-1 mod 8.
REQ-022 SHALL keep led one-hot and led==8'h01<<step at all times.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, cnt=0, tv_lat=0, led=8'h01, step=0, tick=0, regardless of clk.
REQ-024 SHALL, after rst is released mid-operation, restart only through IDLE->RUN per REQ-013; no prior progress is retained.

Verification
REQ-025 SHALL pass: tv=4, allow=1, dir=0 -> tick every 4th cycle; led 01,02,04..80,01; step 0..7,0 after 8 ticks.
REQ-026 SHALL pass: tv=1, allow=1 -> tick stays high continuously; led rotates every cycle.
REQ-027 SHALL pass: tv=5; allow=0 after 3 advancing edges, held 10 cycles, then allow=1 -> state 01->10->01; tick after 2 further advancing edges.
REQ-028 SHALL pass: tv changes 5->3 at cnt=2 -> next tick after 5 total edges, later ticks every 3.
REQ-029 SHALL pass: dir=1 from reset -> first tick gives led=8'h80, step=7; then tv=0 -> state=00, led=8'h01, step=0 next edge.
REQ-030 SHALL pass: rst pulse between clk edges during RUN -> all outputs at reset values before the next edge.
